bsg_two_fifo_rn: RTL and testbench
==================================

# bsg_two_fifo_rn

Two-entry valid/ready buffer that sits directly upstream of the 16-bit `bsg_inv` stage: it accepts words from a producer, holds up to two, and presents the head word on `data_o`, which drives the inverter's `i` input unmodified. It decouples producer and consumer timing with no combinational path from `v_i`/`data_i` to `v_o`/`data_o`, and no path from `yumi_i` to `ready_o`, so it can be dropped between any two stages without lengthening timing paths.

## Interface
- `width_p`, default 16: data width; must match the downstream `bsg_inv` width.
- `ready_then_valid_p`, default 0: 0 means `v_i` may be asserted while `ready_o`=0, and the word is simply not taken. 1 means the producer asserts `v_i` only when `ready_o`=1; violations are flagged by a simulation assertion.
- `clk_i`  input  1  clock; all state updates on rising edge.
- `reset_n_i`  input  1  reset, asynchronous and active-low. Assertion clears state immediately; deassertion is synchronised externally.
- `data_i`  input  `width_p`  producer word.
- `v_i`  input  1  producer word valid.
- `ready_o`  output  1  buffer can accept a word this cycle.
- `data_o`  output  `width_p`  head word; feeds `bsg_inv.i`.
- `v_o`  output  1  `data_o` holds a valid word.
- `yumi_i`  input  1  consumer takes the head word this cycle. Legal only when `v_o`=1.
- `count_o`  output  2  occupancy, 0..2.

## Operation
- Storage: two registers `mem[0..1]`, one read pointer `rptr`, one write pointer `wptr` (1 bit each), plus a `full` flag. Empty is `rptr==wptr && !full`.
- Enqueue: `enq = v_i & ready_o`. `mem[wptr] <= data_i`, then `wptr` toggles.
- Dequeue: `deq = yumi_i & v_o`. `rptr` toggles.
- Full flag update: `full` is set on enqueue without dequeue when `count_o`=1. It is cleared on any dequeue.
- Outputs:
  - `ready_o = ~full & reset_n_i`.
  - `v_o = ~empty`.
  - `data_o = mem[rptr]`.
  - `count_o = {full, ~empty & ~full}`.
- Occupancy 0: `v_o`=0 and `ready_o`=1; a `yumi_i` here is ignored and triggers an assertion.
- Occupancy 1 with both enqueue and dequeue: the new word is written and the head advances; `count_o` stays 1.
- Occupancy 2: `ready_o`=0, so no enqueue occurs. If `ready_then_valid_p`=0, an asserted `v_i` is dropped silently and the producer must hold it. A dequeue gives occupancy 1, and `ready_o` returns to 1 next cycle.
- Pointers wrap 1→0 naturally through the 1-bit toggle; there are no other width rules.
- Reset mid-operation: all stored words are discarded immediately, regardless of handshake state.

## Timing
- Reset (`reset_n_i`=0, asynchronous): `rptr`=`wptr`=0, `full`=0, `mem` cleared to 0.
  - Outputs during reset: `v_o`=0, `ready_o`=0, `data_o`=0, `count_o`=0.
  - First cycle after deassertion: `ready_o`=1.
- Latency: a word enqueued at edge N is visible on `data_o` with `v_o`=1 after edge N (cycle N+1). There is no fall-through.
- Throughput: one word per cycle sustained when `yumi_i` is held high and `v_i` is held high.
- `ready_o` depends only on registered `full` and `reset_n_i`. `v_o` and `data_o` depend only on registers.
- `count_o` reflects post-edge state.

## Structure
- No shared package types are required. If the `bsg_inv` width is centralised, `width_p` derives from the shared width constant in that package.
- One natural sub-module: `bsg_two_fifo_rn_mem`, a 2×`width_p` register file with one write port (`w_v`, `w_addr`, `w_data`), one asynchronous read port, and async active-low clear.
- Control (pointers, full flag) lives in the top module.
- Integration: `bsg_two_fifo_rn.data_o` connects to `bsg_inv.i`. The consumer of `bsg_inv.o` drives `yumi_i`.

## Test plan
- Reset then idle: hold `reset_n_i`=0 for 3 cycles, then release.
  - During reset: `v_o`=0, `ready_o`=0, `count_o`=0, `data_o`=16'h0000.
  - Cycle after release: `ready_o`=1.
- Single pass: enqueue 16'hA5A5 with `yumi_i`=0.
  - Next cycle: `v_o`=1, `data_o`=16'hA5A5, `count_o`=1, and inverter output 16'h5A5A.
- Fill and backpressure: enqueue 16'h0001 and 16'h0002 with `yumi_i`=0, then hold `v_i`=1 with 16'h0003.
  - `ready_o`=0 and `count_o`=2; 16'h0003 is not stored.
  - Then assert `yumi_i`: the outputs are 16'h0001, then 16'h0002, then 16'h0003 once it is accepted.
- Streaming: 10 words 16'h0000..16'h0009 with `v_i`=1 and `yumi_i`=1 continuously.
  - Words appear in order, one per cycle, at 1-cycle latency.
  - `count_o` stays 1 after the first word.
- Simultaneous enqueue/dequeue at occupancy 1: head 16'hFFFF and new word 16'h1234 in the same cycle.
  - Next cycle: `data_o`=16'h1234 and `count_o`=1.
- Async reset mid-stream: drop `reset_n_i` between clock edges while `count_o`=2.
  - `v_o`, `count_o` and `data_o` go to 0 immediately, without waiting for a clock edge.
  - Previously stored words never reappear after release.

Source files
------------

// File: rtl/bsg_two_fifo_rn_pkg.sv
// Shared constants for the two-entry buffer feeding bsg_inv.
// The inverter width lives here so both sides agree.
package bsg_two_fifo_rn_pkg;

  localparam int unsigned inv_width_lp = 16;

endpackage

// File: rtl/bsg_two_fifo_rn_mem.sv
// 2-entry register file: one write port, one async read port,
// asynchronous active-low clear.
module bsg_two_fifo_rn_mem
  import bsg_two_fifo_rn_pkg::*;
#(
  parameter int unsigned width_p = inv_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               w_v_i,
  input  logic               w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic               r_addr_i,
  output logic [width_p-1:0] r_data_o
);

  logic [1:0][width_p-1:0] mem_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q <= '0;
    end else if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bsg_two_fifo_rn.sv
// Two-entry valid/ready buffer; all outputs come from registers,
// so no input-to-output combinational path is created.
module bsg_two_fifo_rn
  import bsg_two_fifo_rn_pkg::*;
#(
  parameter int unsigned width_p            = inv_width_lp,
  parameter bit          ready_then_valid_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [1:0]         count_o
);

  logic rptr_q, rptr_d;
  logic wptr_q, wptr_d;
  logic full_q, full_d;
  logic empty;
  logic enq;
  logic deq;

  assign empty   = (rptr_q == wptr_q) & ~full_q;
  assign ready_o = ~full_q & reset_n_i;
  assign v_o     = ~empty;
  assign count_o = {full_q, ~empty & ~full_q};

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  always_comb begin
    rptr_d = rptr_q ^ deq;
    wptr_d = wptr_q ^ enq;
    full_d = full_q;
    if (deq) begin
      full_d = 1'b0;
    end else if (enq & (rptr_q != wptr_q)) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      full_q <= full_d;
    end
  end

  bsg_two_fifo_rn_mem #(
    .width_p (width_p)
  ) u_mem (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .w_v_i     (enq),
    .w_addr_i  (wptr_q),
    .w_data_i  (data_i),
    .r_addr_i  (rptr_q),
    .r_data_o  (data_o)
  );

  a_yumi_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
  );

  if (ready_then_valid_p) begin : g_rtv
    a_rtv: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) v_i |-> ready_o
    );
  end

endmodule

// File: tb/tb_bsg_two_fifo_rn.sv
// Directed self-checking bench for bsg_two_fifo_rn.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_bsg_two_fifo_rn;

  logic        clk;
  logic        reset_n;
  logic [15:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic        v_o;
  logic        yumi_i;
  logic [1:0]  count_o;

  int n_chk;
  int n_pass;

  bsg_two_fifo_rn dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] inv;

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;

    // reset then idle
    repeat (3) tick();
    chk("rst_v", {31'd0, v_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_count", {30'd0, count_o}, 32'd0);
    chk("rst_data", {16'd0, data_o}, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("rel_ready", {31'd0, ready_o}, 32'd1);
    chk("rel_v", {31'd0, v_o}, 32'd0);

    // single pass
    v_i = 1'b1; data_i = 16'hA5A5;
    tick();
    v_i = 1'b0;
    inv = ~data_o;
    chk("sp_v", {31'd0, v_o}, 32'd1);
    chk("sp_data", {16'd0, data_o}, 32'hA5A5);
    chk("sp_count", {30'd0, count_o}, 32'd1);
    chk("sp_inv", {16'd0, inv}, 32'h5A5A);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk("sp_drain", {30'd0, count_o}, 32'd0);

    // fill and backpressure
    v_i = 1'b1; data_i = 16'h0001;
    tick();
    data_i = 16'h0002;
    tick();
    data_i = 16'h0003;
    chk("bp_ready", {31'd0, ready_o}, 32'd0);
    chk("bp_count", {30'd0, count_o}, 32'd2);
    chk("bp_head", {16'd0, data_o}, 32'h0001);
    tick();
    chk("bp_hold_cnt", {30'd0, count_o}, 32'd2);
    chk("bp_hold_head", {16'd0, data_o}, 32'h0001);
    yumi_i = 1'b1;
    tick();
    chk("bp_d2", {16'd0, data_o}, 32'h0002);
    chk("bp_c2", {30'd0, count_o}, 32'd1);
    chk("bp_r2", {31'd0, ready_o}, 32'd1);
    tick();
    chk("bp_d3", {16'd0, data_o}, 32'h0003);
    chk("bp_c3", {30'd0, count_o}, 32'd1);
    v_i = 1'b0;
    tick();
    yumi_i = 1'b0;
    chk("bp_empty", {30'd0, count_o}, 32'd0);
    chk("bp_empty_v", {31'd0, v_o}, 32'd0);

    // streaming
    v_i = 1'b1; data_i = 16'h0000;
    tick();
    yumi_i = 1'b1;
    for (int i = 1; i < 10; i++) begin
      data_i = 16'(i);
      chk($sformatf("st_d%0d", i - 1), {16'd0, data_o}, 32'(i - 1));
      chk($sformatf("st_c%0d", i - 1), {30'd0, count_o}, 32'd1);
      tick();
    end
    v_i = 1'b0;
    chk("st_d9", {16'd0, data_o}, 32'h0009);
    chk("st_c9", {30'd0, count_o}, 32'd1);
    tick();
    yumi_i = 1'b0;
    chk("st_end", {30'd0, count_o}, 32'd0);

    // simultaneous enq/deq at occupancy 1
    v_i = 1'b1; data_i = 16'hFFFF;
    tick();
    chk("sim_head", {16'd0, data_o}, 32'hFFFF);
    data_i = 16'h1234; yumi_i = 1'b1;
    tick();
    v_i = 1'b0; yumi_i = 1'b0;
    chk("sim_data", {16'd0, data_o}, 32'h1234);
    chk("sim_count", {30'd0, count_o}, 32'd1);
    tick();
    chk("sim_hold", {16'd0, data_o}, 32'h1234);

    // async reset with two words stored
    v_i = 1'b1; data_i = 16'hAAAA;
    tick();
    data_i = 16'hBBBB;
    tick();
    v_i = 1'b0;
    chk("ar_pre_cnt", {30'd0, count_o}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_v", {31'd0, v_o}, 32'd0);
    chk("ar_count", {30'd0, count_o}, 32'd0);
    chk("ar_data", {16'd0, data_o}, 32'h0);
    chk("ar_ready", {31'd0, ready_o}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_post_v", {31'd0, v_o}, 32'd0);
    chk("ar_post_cnt", {30'd0, count_o}, 32'd0);
    chk("ar_post_data", {16'd0, data_o}, 32'h0);
    chk("ar_post_rdy", {31'd0, ready_o}, 32'd1);
    v_i = 1'b1; data_i = 16'h0C0C;
    tick();
    v_i = 1'b0;
    chk("ar_new", {16'd0, data_o}, 32'h0C0C);
    chk("ar_new_cnt", {30'd0, count_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
